// File: rtl/soc_bus_fabric.sv
// CPU-to-slave interconnect: windowed address decode, per-slave wait states,
// optional byte-swap lanes, delayed read mux and sticky unmapped-access trap.
module soc_bus_fabric #(
  parameter int                 NSLV          = 3,
  parameter logic [NSLV*32-1:0] SLV_BASE      = {32'hE1000000, 32'h40000000, 32'h00000000},
  parameter logic [NSLV*32-1:0] SLV_MASK      = {32'hFF000000, 32'hF0000000, 32'hF0000000},
  parameter logic [NSLV*4-1:0]  SLV_WAIT      = {4'd1, 4'd2, 4'd0},
  parameter logic [NSLV-1:0]    SLV_SWAP      = 3'b100,
  parameter logic [31:0]        UNMAPPED_DATA = 32'hDEADBEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic [3:0]           cpu_we_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [NSLV-1:0]      slv_sel_o,
  output logic [31:0]          slv_addr_o,
  output logic [31:0]          slv_data_o,
  output logic [3:0]           slv_we_o,
  input  logic [NSLV*32-1:0]   slv_data_i,
  input  logic                 err_clr_i,
  output logic                 err_irq_o,
  output logic [31:0]          err_addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             stall;
  logic [NSLV-1:0]  hit, hit_dly, rd_hit;
  logic             mapped, win_swap;
  logic [3:0]       win_wait;
  logic             unmapped;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    hit       = '0;
    slv_sel_o = '0;
    win_wait  = 4'd0;
    win_swap  = 1'b0;
    for (int k = 0; k < NSLV; k++)
      hit[k] = cpu_req_i && ((cpu_addr_i & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]);
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (hit[k]) begin
        slv_sel_o    = '0;
        slv_sel_o[k] = 1'b1;
        win_wait     = SLV_WAIT[4*k +: 4];
        win_swap     = SLV_SWAP[k];
      end
    end
  end

  assign mapped   = |hit;
  assign unmapped = cpu_req_i && !mapped;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mapped && (win_wait != 4'd0)) begin
          stall     = 1'b1;
          cnt_nxt   = win_wait - 4'd1;
          state_nxt = (win_wait == 4'd1) ? S_RELEASE : S_WAIT;
        end
      end
      S_WAIT: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1)
          state_nxt = S_RELEASE;
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      hit_dly <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!stall)
        hit_dly <= hit;
    end
  end

  // Reset gates the stall and strobe directly so an aborted access never writes.
  assign cpu_stall_o = stall && !rst_i;
  assign slv_we_o    = (mapped && !stall && !rst_i) ? cpu_we_i : 4'b0;
  assign slv_addr_o  = cpu_addr_i;
  assign slv_data_o  = win_swap ? bswap(cpu_data_i) : cpu_data_i;

  // Current hit or last cycle's hit selects the source, covering 1-cycle slaves.
  assign rd_hit = hit | hit_dly;
  always_comb begin
    cpu_data_o = UNMAPPED_DATA;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (rd_hit[k])
        cpu_data_o = SLV_SWAP[k] ? bswap(slv_data_i[32*k +: 32]) : slv_data_i[32*k +: 32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_irq_o  <= 1'b0;
      err_addr_o <= 32'd0;
    end else if (unmapped) begin
      err_irq_o <= 1'b1;
      if (!err_irq_o || err_clr_i)
        err_addr_o <= cpu_addr_i;
    end else if (err_clr_i) begin
      err_irq_o  <= 1'b0;
      err_addr_o <= 32'd0;
    end
  end

endmodule

// File: doc/soc_bus_fabric.md
Name: soc_bus_fabric

Overview:
- Parametrised CPU-to-slave memory-mapped interconnect for the HF-RISC-V SoC.
- Replaces hand-written address decode and read-mux logic in the top level with a configurable fabric.
- Handles NSLV slaves, each with its own base/mask window, per-slave wait states and an optional byte-swap lane.
- Traps and records unmapped accesses, raising a sticky error interrupt.

Parameters:
NSLV, 3, number of slave ports (1..8)
SLV_BASE, {32'hE1000000, 32'h40000000, 32'h00000000}, packed NSLV x 32 base addresses; slave k in bits [32k+31:32k]
SLV_MASK, {32'hFF000000, 32'hF0000000, 32'hF0000000}, packed NSLV x 32 decode masks
SLV_WAIT, {4'd1, 4'd2, 4'd0}, packed NSLV x 4 wait-state count per slave (0..15)
SLV_SWAP, 3'b100, bit k=1 byte-reverses write and read data for slave k
UNMAPPED_DATA, 32'hDEADBEEF, read value returned when no slave is selected

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
cpu_req_i  in  1  CPU access valid (read or write)
cpu_addr_i  in  32  CPU address
cpu_data_i  in  32  CPU write data
cpu_we_i  in  4  CPU byte write enables
cpu_data_o  out  32  read data to CPU
cpu_stall_o  out  1  holds CPU while wait states run
slv_sel_o  out  NSLV  one-hot slave select
slv_addr_o  out  32  address to slaves (cpu_addr_i passthrough)
slv_data_o  out  32  write data to slaves, swapped per selected slave
slv_we_o  out  4  gated byte write enables
slv_data_i  in  NSLV*32  slave read data; slave k in bits [32k+31:32k]
err_clr_i  in  1  clears error flag
err_irq_o  out  1  sticky unmapped-access flag
err_addr_o  out  32  address of first unmapped access since last clear

Behaviour:
- Reset is async and forces: state IDLE, cnt 0, hit_dly 0, err_irq_o 0, err_addr_o 0, cpu_stall_o 0.
- Decode (combinational):
  - hit[k] = cpu_req_i & ((cpu_addr_i & MASK[k]) == BASE[k]).
  - Lowest index wins on overlapping windows; slv_sel_o is one-hot of the winner, else 0.
  - mapped = |hit; W = SLV_WAIT[winner].
- Wait FSM, states IDLE, WAIT, RELEASE:
  - IDLE: if mapped & W>0: cpu_stall_o=1 and cnt<=W-1; next state RELEASE if W==1, else WAIT. Otherwise cpu_stall_o=0 and state stays IDLE.
  - WAIT: cpu_stall_o=1, cnt<=cnt-1; go to RELEASE when cnt==1.
  - RELEASE: cpu_stall_o=0; the access completes this cycle; next state IDLE.
  - Net effect: exactly W stall cycles per access. A back-to-back access is decoded fresh in the following IDLE.
- Writes:
  - slv_we_o = cpu_we_i only when mapped & cpu_stall_o==0, else 4'b0. Each access therefore issues exactly one write strobe.
  - slv_data_o = byte-reversed cpu_data_i if SLV_SWAP[winner], else cpu_data_i.
- Reads (supports slaves with 1-cycle read latency):
  - hit_dly <= hit every cycle in which cpu_stall_o==0; it holds during stalls.
  - Read source is the lowest k with (hit[k] | hit_dly[k]).
  - cpu_data_o = slave k data, byte-reversed if SLV_SWAP[k]. If no such k, cpu_data_o = UNMAPPED_DATA.
- Errors:
  - cpu_req_i & ~mapped at a clock edge sets err_irq_o on the next cycle.
  - err_addr_o captures cpu_addr_i only if err_irq_o was 0 (first error held).
  - err_clr_i clears err_irq_o and err_addr_o next cycle.
  - If err_clr_i and a new unmapped access coincide, the error wins: err_irq_o stays 1 and err_addr_o takes the new address.
  - An unmapped access never stalls.
- cpu_req_i dropping mid-WAIT does not abort the count; the FSM still runs to RELEASE.
- rst_i asserted mid-WAIT: stall drops asynchronously, FSM returns to IDLE, no write is issued.

Test Plan:
- Write 0x11223344, we=4'hF, to 0x40000010 (slave1, W=2) -> cpu_stall_o high for 2 cycles; slv_we_o=4'hF only in the RELEASE cycle; slv_data_o=0x11223344; slv_sel_o=3'b010.
- Read 0xE1000004 (slave2, W=1, swap) with slave2 returning 0xAABBCCDD -> 1 stall cycle; cpu_data_o=0xDDCCBBAA; write 0x01020304 there -> slv_data_o=0x04030201.
- Read 0x00000100 (slave0, W=0) then next cycle request 0x40000000 -> no stall on the first access; cpu_data_o shows slave0 data in the delayed cycle (hit_dly); the second access stalls 2 cycles.
- Access 0x80000000, then 0x90000000 -> err_irq_o=1 from the next cycle; err_addr_o=0x80000000 (first held); cpu_data_o=0xDEADBEEF; no stall; slv_we_o=0.
- Pulse err_clr_i in the same cycle as a request to 0xA0000000 -> err_irq_o stays 1; err_addr_o=0xA0000000. Clear alone -> err_irq_o=0, err_addr_o=0.
- Assert rst_i during the second stall cycle of a slave1 write -> cpu_stall_o=0 immediately; slv_we_o never asserted; FSM in IDLE; outputs at reset values.
